onehot_encoder: RTL and testbench
=================================

# onehot_encoder

Sequential one-hot/multi-hot to binary encoder, the inverse of the team's 2-to-4 decoder. It accepts a WIDTH-bit request vector over a valid/ready handshake and emits the bit position of every set bit, lowest first, one index per output transfer. The last index of each vector is tagged, and malformed inputs (zero or multi-hot) are flagged. It sits between one-hot select/grant logic and anything that needs a compact binary index stream.

## Interface
- WIDTH, 4, input vector width; legal range 2..64.
- IDX_W, $clog2(WIDTH), index width; derived, not overridden.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- inValid  input  1  dataIn valid
- inReady  output  1  block can accept dataIn this cycle
- dataIn  input  WIDTH  request vector
- coldIn  input  1  sampled with dataIn; 1 = dataIn is one-cold (active-low), inverted before use
- outValid  output  1  index valid
- outReady  input  1  downstream accepts index
- index  output  IDX_W  bit position of current set bit
- outLast  output  1  current index is the final one for this vector
- multiHot  output  1  the source vector had more than one bit set; constant across its beats
- zeroIn  output  1  the source vector had no bits set

## Operation
- Effective vector: v = coldIn ? ~dataIn : dataIn, sampled on an input transfer (inValid && inReady).
- State: pending mask register (WIDTH), outValid register, flag registers. Two states:
  - IDLE: outValid=0, pending=0.
  - BUSY: outValid=1.
- Input transfer with v != 0:
  - pending <= v.
  - multiHot <= (popcount(v) > 1).
  - zeroIn <= 0.
- Input transfer with v == 0:
  - One beat: index=0, outLast=1, zeroIn=1, multiHot=0, pending=0.
- Combinational outputs while BUSY:
  - index = position of lowest set bit of pending.
  - outLast = pending has at most one bit set.
- Output transfer (outValid && outReady):
  - If outLast=0: clear the lowest set bit of pending; stay BUSY.
  - If outLast=1: go to IDLE, unless an input transfer occurs in the same cycle, in which case load the new vector.
- inReady = !outValid || (outReady && outLast). This gives back-to-back vectors with no bubble.
- While outValid=1 and outReady=0: index, outLast, multiHot and zeroIn hold stable.
- dataIn and coldIn are ignored when inValid=0 or inReady=0.
- Reset values:
  - outValid=0, inReady=1, index=0, outLast=0.
  - multiHot=0, zeroIn=0, pending=0.

## Timing
- Latency: an input transfer at edge T gives outValid=1 from T+1, carrying the lowest index.
- Throughput: one index per cycle while outReady=1. A vector with k set bits occupies k cycles (1 cycle if zero).
- Vector sequence A (kA bits), then B: B's first index appears the cycle after A's last transfer, provided inValid was high during that last transfer.
- Bit WIDTH-1 set alone: index=WIDTH-1, outLast=1.
- All bits set: WIDTH beats, indices 0..WIDTH-1 in order, outLast only on the last beat.
- Reset asserted mid-burst: the next edge returns all outputs to reset values and drops the remaining beats. No partial output after rst deasserts.
- rst and inValid high together: reset wins and the input is not accepted.

## Test plan
- Reset, then dataIn=4'b0100, coldIn=0, outReady=1 -> one beat next cycle: index=2, outLast=1, multiHot=0, zeroIn=0; then outValid=0.
- dataIn=4'b1011, coldIn=0, outReady=1 -> three consecutive beats with index 0,1,3; outLast only on 3; multiHot=1 on all three; inReady=0 until the third beat.
- dataIn=4'b1101, coldIn=1 (effective 0010) -> single beat index=1, outLast=1; then dataIn=0, coldIn=0 -> single beat index=0, zeroIn=1, outLast=1.
- Backpressure: dataIn=4'b0110 with outReady held low for 3 cycles -> index=1 held stable with outValid=1 and inReady=0; release gives index 1 then 2, no loss or duplication.
- Back-to-back: 4'b1000 then 4'b0001 with inValid continuously high and outReady=1 -> index 3 then 0 on consecutive cycles, both with outLast=1, no bubble.
- dataIn=4'b1111 accepted; after 2 output beats assert rst for one cycle -> outValid=0, pending cleared, inReady=1; no further indices from that vector.

Source files
------------

// File: rtl/onehot_encoder.sv
`timescale 1ns/1ps
// Streams the bit positions of every set bit of a request vector, lowest first,
// one index per output transfer; the last index is tagged and malformed vectors are flagged.
module onehot_encoder #(
  parameter int WIDTH = 4,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             coldIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [IDX_W-1:0] index,
  output logic             outLast,
  output logic             multiHot,
  output logic             zeroIn
);

  logic [WIDTH-1:0] pending_reg;
  logic             valid_reg;
  logic             multi_reg;
  logic             zero_reg;

  logic [WIDTH-1:0] vec;
  logic [WIDTH-1:0] pending_rest;
  logic [IDX_W-1:0] low_idx;
  logic             last_beat;
  logic             in_fire;
  logic             out_fire;

  assign vec          = coldIn ? ~dataIn : dataIn;
  // pending with its lowest set bit cleared; zero means at most one bit remains
  assign pending_rest = pending_reg & (pending_reg - WIDTH'(1));
  assign last_beat    = valid_reg && (pending_rest == '0);

  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_reg[i]) low_idx = IDX_W'(i);
    end
  end

  assign inReady  = !valid_reg || (outReady && last_beat);
  assign in_fire  = inValid && inReady;
  assign out_fire = valid_reg && outReady;

  assign outValid = valid_reg;
  assign index    = low_idx;
  assign outLast  = last_beat;
  assign multiHot = multi_reg;
  assign zeroIn   = zero_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
      valid_reg   <= 1'b0;
      multi_reg   <= 1'b0;
      zero_reg    <= 1'b0;
    end else begin
      if (out_fire) begin
        if (last_beat) begin
          pending_reg <= '0;
          valid_reg   <= 1'b0;
          multi_reg   <= 1'b0;
          zero_reg    <= 1'b0;
        end else begin
          pending_reg <= pending_rest;
        end
      end
      // a new vector overrides the drain of the previous one on the same edge
      if (in_fire) begin
        pending_reg <= vec;
        valid_reg   <= 1'b1;
        multi_reg   <= (vec & (vec - WIDTH'(1))) != '0;
        zero_reg    <= (vec == '0);
      end
    end
  end

endmodule

// File: tb/tb_onehot_encoder.sv
`timescale 1ns/1ps
// Scoreboard bench for onehot_encoder: expected beats are queued on every input
// transfer and compared as each output transfer happens.
module tb_onehot_encoder;

  localparam int WIDTH = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [WIDTH-1:0] dataIn = '0;
  logic             coldIn = 1'b0;
  logic             outValid;
  logic             outReady = 1'b1;
  logic [IDX_W-1:0] index;
  logic             outLast;
  logic             multiHot;
  logic             zeroIn;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             multi;
    logic             zero;
  } beat_t;

  beat_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  bit rand_ready = 1'b0;

  onehot_encoder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .inValid(inValid), .inReady(inReady), .dataIn(dataIn), .coldIn(coldIn),
    .outValid(outValid), .outReady(outReady), .index(index),
    .outLast(outLast), .multiHot(multiHot), .zeroIn(zeroIn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_vec(input logic [WIDTH-1:0] v);
    int n = 0;
    int k = 0;
    beat_t b;
    for (int i = 0; i < WIDTH; i++) if (v[i]) n++;
    if (n == 0) begin
      b = '{idx: '0, last: 1'b1, multi: 1'b0, zero: 1'b1};
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) begin
          k++;
          b = '{idx: IDX_W'(i), last: (k == n), multi: (n > 1), zero: 1'b0};
          exp_q.push_back(b);
        end
      end
    end
  endfunction

  // monitor: pop on output transfer, push on input transfer
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (outValid && outReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("index", 64'(index), 64'(e.idx));
          check("outLast", 64'(outLast), 64'(e.last));
          check("multiHot", 64'(multiHot), 64'(e.multi));
          check("zeroIn", 64'(zeroIn), 64'(e.zero));
          $display("beat idx=%0d last=%0b multi=%0b zero=%0b", index, outLast, multiHot, zeroIn);
        end
      end
      if (inValid && inReady) begin
        push_vec(coldIn ? ~dataIn : dataIn);
        $display("accept data=%b cold=%0b", dataIn, coldIn);
      end
    end
  end

  // drive at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [WIDTH-1:0] d, input logic c);
    int n = 0;
    dataIn = d;
    coldIn = c;
    inValid = 1'b1;
    @(negedge clk);
    while (!inReady && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!inReady) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || outValid) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("drain_timeout", 64'(exp_q.size()), 0);
    check("idle_outValid", 64'(outValid), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_outValid"}, 64'(outValid), 0);
    check({tag, "_inReady"}, 64'(inReady), 1);
    check({tag, "_index"}, 64'(index), 0);
    check({tag, "_outLast"}, 64'(outLast), 0);
    check({tag, "_multiHot"}, 64'(multiHot), 0);
    check({tag, "_zeroIn"}, 64'(zeroIn), 0);
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 outReady = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // single bit, then latency check
    @(posedge clk); #1;
    send(4'b0100, 1'b0);
    check("latency_outValid", 64'(outValid), 1);
    drain();

    // multi-hot: three beats, inReady low until last beat
    @(posedge clk); #1;
    send(4'b1011, 1'b0);
    @(negedge clk); check("mh_inReady0", 64'(inReady), 0);
    @(negedge clk); check("mh_inReady1", 64'(inReady), 0);
    @(negedge clk); check("mh_inReady2", 64'(inReady), 1);
    drain();

    // one-cold input, then zero vector
    @(posedge clk); #1;
    send(4'b1101, 1'b1);
    drain();
    @(posedge clk); #1;
    send(4'b0000, 1'b0);
    drain();

    // backpressure holds the first index
    @(posedge clk); #1;
    outReady = 1'b0;
    send(4'b0110, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_outValid", 64'(outValid), 1);
      check("bp_index", 64'(index), 1);
      check("bp_inReady", 64'(inReady), 0);
      if (i < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    outReady = 1'b1;
    drain();

    // back-to-back vectors with no bubble
    @(posedge clk); #1;
    dataIn = 4'b1000; coldIn = 1'b0; inValid = 1'b1;
    @(posedge clk); #1;
    dataIn = 4'b0001;
    @(negedge clk);
    check("b2b_first_valid", 64'(outValid), 1);
    check("b2b_first_index", 64'(index), 3);
    check("b2b_inReady", 64'(inReady), 1);
    @(posedge clk); #1;
    inValid = 1'b0;
    @(negedge clk);
    check("b2b_second_valid", 64'(outValid), 1);
    check("b2b_second_index", 64'(index), 0);
    drain();

    // reset mid-burst drops remaining beats
    @(posedge clk); #1;
    send(4'b1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    repeat (3) begin
      @(negedge clk);
      check("midrst_quiet", 64'(outValid), 0);
    end

    // reset wins over a simultaneous input
    @(posedge clk); #1;
    rst = 1'b1; inValid = 1'b1; dataIn = 4'b0001;
    @(posedge clk); #1;
    rst = 1'b0; inValid = 1'b0;
    @(negedge clk);
    check("rstwin_outValid", 64'(outValid), 0);

    // full vector in order, then random traffic with random backpressure
    @(posedge clk); #1;
    send(4'b1111, 1'b0);
    drain();
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      send(WIDTH'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    outReady = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
